m65_speed_regs: RTL and testbench

- Register/decode stage directly upstream of the CPU speed controller.
- Owns the speed-related control bits and drives the speed controller's inputs: vicii_2mhz, viciii_fast, viciv_fast, speed_gate, speed_gate_enable, force_fast.
- Decodes CPU writes to $D030, $D031 and $D054, and to CPU port $00 (C65 speed gate).
- Synchronises and debounces the external turbo switch, and flags every change of the effective speed selection.

---
 rtl/m65_speed_regs.sv | 181 ++++++++++++++++++
 tb/tb_m65_speed_regs.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m65_speed_regs.sv
// Speed-control register stage: decodes $D030/$D031/$D054 and CPU port $00,
// debounces the turbo switch and flags changes of the effective speed selection.
module m65_speed_regs #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd40000,
    parameter logic [7:0]  D031_RESET      = 8'h40,
    parameter logic [7:0]  D054_RESET      = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        port_sel,
    input  logic [11:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    input  logic        viciv_unlocked,
    input  logic        ext_fast_sw,
    output logic        vicii_2mhz,
    output logic        viciii_fast,
    output logic        viciv_fast,
    output logic        speed_gate,
    output logic        speed_gate_enable,
    output logic        force_fast,
    output logic        speed_change
);

    // Tuple order: {vicii_2mhz, viciii_fast, viciv_fast, speed_gate, force_fast}
    localparam logic [4:0] TUPLE_RESET = {1'b0, D031_RESET[6], D054_RESET[6], 1'b1, 1'b0};

    logic [7:0]  d030_r, d031_r, d054_r, ddr00_r;
    logic        speed_gate_r, speed_gate_enable_r;
    logic [7:0]  rdata_r;
    logic        rdata_valid_r;
    logic        sync1_r, sw_s;
    logic [15:0] dbnc_cnt_r;
    logic        force_fast_r;
    logic [4:0]  tuple_s, tuple_r;
    logic        speed_change_r;

    logic        wr_d030_s, wr_d031_s, wr_d054_s, wr_port_s;
    logic [7:0]  rd_mux_s;

    // Write address decode
    always_comb begin
        wr_d030_s = 1'b0;
        wr_d031_s = 1'b0;
        wr_d054_s = 1'b0;
        wr_port_s = 1'b0;
        if (we) begin
            if (port_sel) begin
                wr_port_s = 1'b1;
            end else begin
                case (addr)
                    12'h030: wr_d030_s = 1'b1;
                    12'h031: wr_d031_s = 1'b1;
                    12'h054: wr_d054_s = viciv_unlocked;
                    default: wr_d030_s = 1'b0;
                endcase
            end
        end else begin
            wr_port_s = 1'b0;
        end
    end

    // Read data selection; unmapped offsets float high like open bus
    always_comb begin
        rd_mux_s = 8'hFF;
        if (port_sel) begin
            rd_mux_s = ddr00_r;
        end else begin
            case (addr)
                12'h030: rd_mux_s = d030_r;
                12'h031: rd_mux_s = d031_r;
                12'h054: rd_mux_s = d054_r;
                default: rd_mux_s = 8'hFF;
            endcase
        end
    end

    // Shadow registers and C65 speed-gate pokes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d030_r              <= 8'h00;
            d031_r              <= D031_RESET;
            d054_r              <= D054_RESET;
            ddr00_r             <= 8'h00;
            speed_gate_r        <= 1'b1;
            speed_gate_enable_r <= 1'b0;
        end else begin
            if (wr_d030_s) d030_r <= wdata;
            else           d030_r <= d030_r;
            if (wr_d031_s) d031_r <= wdata;
            else           d031_r <= d031_r;
            if (wr_d054_s) d054_r <= wdata;
            else           d054_r <= d054_r;
            if (wr_port_s) begin
                ddr00_r <= wdata;
                if (wdata == 8'h41) begin
                    speed_gate_r        <= 1'b0;
                    speed_gate_enable_r <= 1'b1;
                end else if (wdata == 8'h40) begin
                    speed_gate_r        <= 1'b1;
                    speed_gate_enable_r <= 1'b1;
                end else begin
                    speed_gate_r        <= speed_gate_r;
                    speed_gate_enable_r <= speed_gate_enable_r;
                end
            end else begin
                ddr00_r <= ddr00_r;
            end
        end
    end

    // Registered read port; data sampled before any same-edge write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r       <= 8'h00;
            rdata_valid_r <= 1'b0;
        end else begin
            rdata_valid_r <= re;
            if (re) rdata_r <= rd_mux_s;
            else    rdata_r <= rdata_r;
        end
    end

    // Turbo switch synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sync1_r <= ext_fast_sw;
            sw_s    <= sync1_r;
        end
    end

    // Debounce: switch must disagree with force_fast for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbnc_cnt_r   <= 16'd0;
            force_fast_r <= 1'b0;
        end else if (sw_s == force_fast_r) begin
            dbnc_cnt_r   <= 16'd0;
            force_fast_r <= force_fast_r;
        end else if (dbnc_cnt_r == (DEBOUNCE_CYCLES - 16'd1)) begin
            dbnc_cnt_r   <= 16'd0;
            force_fast_r <= sw_s;
        end else if (dbnc_cnt_r != 16'hFFFF) begin
            dbnc_cnt_r   <= dbnc_cnt_r + 16'd1;
            force_fast_r <= force_fast_r;
        end else begin
            dbnc_cnt_r   <= dbnc_cnt_r;
            force_fast_r <= force_fast_r;
        end
    end

    assign tuple_s = {d030_r[0], d031_r[6], d054_r[6], speed_gate_r, force_fast_r};

    // Change detector; reset copy matches the reset tuple so no pulse at release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tuple_r        <= TUPLE_RESET;
            speed_change_r <= 1'b0;
        end else begin
            tuple_r        <= tuple_s;
            speed_change_r <= (tuple_s != tuple_r);
        end
    end

    assign rdata             = rdata_r;
    assign rdata_valid       = rdata_valid_r;
    assign vicii_2mhz        = d030_r[0];
    assign viciii_fast       = d031_r[6];
    assign viciv_fast        = d054_r[6];
    assign speed_gate        = speed_gate_r;
    assign speed_gate_enable = speed_gate_enable_r;
    assign force_fast        = force_fast_r;
    assign speed_change      = speed_change_r;

endmodule

// File: tb/tb_m65_speed_regs.sv
// Self-checking bench for m65_speed_regs: read scoreboard plus per-feature tasks.
module tb_m65_speed_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        port_sel = 1'b0;
    logic [11:0] addr = 12'h000;
    logic [7:0]  wdata = 8'h00;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        viciv_unlocked = 1'b0;
    logic        ext_fast_sw = 1'b0;
    logic        vicii_2mhz, viciii_fast, viciv_fast;
    logic        speed_gate, speed_gate_enable, force_fast, speed_change;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];

    m65_speed_regs #(.DEBOUNCE_CYCLES(16'd50)) dut (
        .clk(clk), .reset(reset), .port_sel(port_sel), .addr(addr),
        .wdata(wdata), .we(we), .re(re), .rdata(rdata), .rdata_valid(rdata_valid),
        .viciv_unlocked(viciv_unlocked), .ext_fast_sw(ext_fast_sw),
        .vicii_2mhz(vicii_2mhz), .viciii_fast(viciii_fast), .viciv_fast(viciv_fast),
        .speed_gate(speed_gate), .speed_gate_enable(speed_gate_enable),
        .force_fast(force_fast), .speed_change(speed_change)
    );

    always #5 clk = ~clk;

    // Read scoreboard and speed_change pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (speed_change) pulse_cnt++;
        if (rdata_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rdata_valid=1 rdata=%h, required no read pending", rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h, expected %h", rdata, e);
                end
            end
        end
    end

    task automatic do_write(input logic ps, input logic [11:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        port_sel = ps; addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic do_read(input logic ps, input logic [11:0] a, input logic [7:0] e);
        @(posedge clk); #1;
        port_sel = ps; addr = a; re = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        re = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({viciii_fast, viciv_fast, vicii_2mhz, speed_gate, speed_gate_enable, force_fast, speed_change, rdata_valid} !== 8'b1001_0000) begin
            errors++;
            $display("FAIL reset_outs: got %b, expected 10010000",
                {viciii_fast, viciv_fast, vicii_2mhz, speed_gate, speed_gate_enable, force_fast, speed_change, rdata_valid});
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h, expected 00", rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (speed_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got %b, expected 0", speed_change);
        end
    endtask

    task automatic test_speed_gate;
        int p0;
        p0 = pulse_cnt;
        do_write(1'b1, 12'h000, 8'h41);
        checks++;
        if ({speed_gate, speed_gate_enable} !== 2'b01) begin
            errors++;
            $display("FAIL gate_41: got %b, expected 01", {speed_gate, speed_gate_enable});
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL gate_41_pulse: got %0d pulses, expected 1", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        do_write(1'b1, 12'h000, 8'h40);
        checks++;
        if ({speed_gate, speed_gate_enable} !== 2'b11) begin
            errors++;
            $display("FAIL gate_40: got %b, expected 11", {speed_gate, speed_gate_enable});
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL gate_40_pulse: got %0d pulses, expected 1", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        do_write(1'b1, 12'h000, 8'h2F);
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({speed_gate, speed_gate_enable} !== 2'b11 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL gate_2f: got gate=%b pulses=%0d, expected 11 and 0",
                {speed_gate, speed_gate_enable}, pulse_cnt - p0);
        end
        do_read(1'b1, 12'h000, 8'h2F);
    endtask

    task automatic test_d054;
        int p0;
        p0 = pulse_cnt;
        viciv_unlocked = 1'b0;
        do_write(1'b0, 12'h054, 8'h40);
        checks++;
        if (viciv_fast !== 1'b0) begin
            errors++;
            $display("FAIL d054_locked: got %b, expected 0", viciv_fast);
        end
        do_read(1'b0, 12'h054, 8'h00);
        viciv_unlocked = 1'b1;
        do_write(1'b0, 12'h054, 8'h40);
        checks++;
        if (viciv_fast !== 1'b1) begin
            errors++;
            $display("FAIL d054_unlocked: got %b, expected 1", viciv_fast);
        end
        do_read(1'b0, 12'h054, 8'h40);
        viciv_unlocked = 1'b0;
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL d054_pulse: got %0d pulses, expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulse_cnt;
        @(posedge clk); #1 ext_fast_sw = 1'b1;
        repeat (20) @(posedge clk);
        #1 ext_fast_sw = 1'b0;
        repeat (80) @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b0 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL glitch: got force_fast=%b pulses=%0d, expected 0 and 0", force_fast, pulse_cnt - p0);
        end
    endtask

    task automatic test_turbo;
        int p0;
        p0 = pulse_cnt;
        @(posedge clk); #1 ext_fast_sw = 1'b1;
        repeat (51) @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b0) begin
            errors++;
            $display("FAIL turbo_early: got %b at edge 51, expected 0", force_fast);
        end
        @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b1) begin
            errors++;
            $display("FAIL turbo_edge: got %b at edge 52, expected 1", force_fast);
        end
        repeat (48) @(posedge clk); #1;
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL turbo_pulse: got %0d pulses, expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_same_cycle;
        @(posedge clk); #1;
        port_sel = 1'b0; addr = 12'h031; wdata = 8'h00; we = 1'b1; re = 1'b1;
        exp_q.push_back(8'h40);
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        checks++;
        if (viciii_fast !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_wr: viciii_fast=%b, expected 0", viciii_fast);
        end
        @(posedge clk); #1;
        do_read(1'b0, 12'h031, 8'h00);
        do_read(1'b0, 12'h0FF, 8'hFF);
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        port_sel = 1'b0; re = 1'b1;
        addr = 12'h030; exp_q.push_back(8'h00);
        @(posedge clk); #1;
        addr = 12'h054; exp_q.push_back(8'h40);
        @(posedge clk); #1;
        addr = 12'h123; exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        re = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        ext_fast_sw = 1'b0;
        repeat (60) @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_release: force_fast=%b, expected 0", force_fast);
        end
        do_write(1'b0, 12'h030, 8'h01);
        checks++;
        if (vicii_2mhz !== 1'b1) begin
            errors++;
            $display("FAIL d030_write: vicii_2mhz=%b, expected 1", vicii_2mhz);
        end
        ext_fast_sw = 1'b1;
        repeat (32) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({viciii_fast, viciv_fast, vicii_2mhz, speed_gate, speed_gate_enable, force_fast, speed_change, rdata_valid} !== 8'b1001_0000
            || rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b rdata=%h, expected 10010000 rdata=00",
                {viciii_fast, viciv_fast, vicii_2mhz, speed_gate, speed_gate_enable, force_fast, speed_change, rdata_valid}, rdata);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (51) @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_early: force_fast=%b at edge 51, expected 0", force_fast);
        end
        @(posedge clk); #1;
        checks++;
        if (force_fast !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_full: force_fast=%b at edge 52, expected 1", force_fast);
        end
    endtask

    initial begin
        test_reset();
        test_speed_gate();
        test_d054();
        test_glitch();
        test_turbo();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_missing: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
